dht11_sensor_model: RTL and testbench
=====================================

Name: dht11_sensor_model

Overview:
- Synthesizable single-wire responder that plays the DHT11 sensor role on the `dht_io` bus.
- Detects a host start pulse, then transmits the DHT11 response preamble followed by a 40-bit frame.
- Frame content: humidity integer/decimal, temperature integer/decimal, checksum.
- Used as an on-board or loopback target for the dht11 host controller, and as a bench stimulus source.

Parameters:
- START_MIN_US, 18000, minimum host low time (in ticks) accepted as a start request
- WAIT_US, 30, delay after host releases the bus before the responder drives
- RESP_LOW_US, 80, response low phase
- RESP_HIGH_US, 80, response high (released) phase
- BIT_LOW_US, 50, low phase preceding every data bit and the trailing end pulse
- BIT0_HIGH_US, 26, released phase for a '0' bit
- BIT1_HIGH_US, 70, released phase for a '1' bit
- CNT_W, 15, timing counter width; must hold START_MIN_US

Ports:
- clk, input, 1, system clock
- reset, input, 1, asynchronous, active-low reset
- tick, input, 1, 1 us single-cycle enable from baud_tick_gen
- enable, input, 1, 1 = respond to start requests
- humidity_int, input, 8, frame byte 0
- humidity_dec, input, 8, frame byte 1
- temperature_int, input, 8, frame byte 2
- temperature_dec, input, 8, frame byte 3
- dht_io, inout, 1, open-drain bus: drives 0 or z, never 1
- busy, output, 1, high from start acceptance until end of frame
- frame_done, output, 1, one-clk pulse when the bus is released after the end pulse
- start_seen, output, 1, one-clk pulse when a valid start pulse is accepted

Behaviour:
- Reset (reset=0):
  - State IDLE; bus released (z).
  - busy=0, frame_done=0, start_seen=0.
  - Counters, bit index and shift register cleared.
  - Takes effect immediately and asynchronously, including mid-frame; the bus is released the same instant.
- Input path: dht_io sampled through a 2-flop synchronizer (din_s); all decisions use din_s.
- Timing: all durations are counted in tick pulses only. The counter resets on every state entry.
- IDLE:
  - While din_s=0 and enable=1, increment low_cnt per tick; low_cnt saturates at START_MIN_US.
  - On din_s 0->1:
    - if low_cnt ≥ START_MIN_US: pulse start_seen, go to WAIT;
    - otherwise discard.
  - low_cnt clears whenever din_s=1.
  - With enable=0, low_cnt is held at 0.
- WAIT:
  - On entry, latch the four input bytes plus checksum = (sum of 4 bytes) mod 256 into a 40-bit shift register, MSB first: byte0[7] first, checksum[0] last.
  - busy=1.
  - After WAIT_US ticks, go to RESP_LOW.
  - If din_s=0 at any time in WAIT (host still active or collision): abort to IDLE, busy=0, no frame_done.
- RESP_LOW: drive 0 for RESP_LOW_US ticks, then go to RESP_HIGH.
- RESP_HIGH: release for RESP_HIGH_US ticks, then go to BIT_LOW.
- BIT_LOW:
  - Drive 0 for BIT_LOW_US ticks.
  - Then go to BIT_HIGH if bit_idx < 40, else to END.
- BIT_HIGH:
  - Release for BIT1_HIGH_US ticks if the current MSB is 1, else BIT0_HIGH_US ticks.
  - Then shift left, bit_idx += 1, go to BIT_LOW.
- END:
  - This is the 41st BIT_LOW (trailing 50 us low); once done, release the bus.
  - Pulse frame_done, busy=0, go to IDLE.
- Frame data is frozen from WAIT entry to frame_done; input byte changes mid-frame do not affect the current frame.
- enable deasserted mid-frame: the frame completes normally; only new starts are blocked.
- No host monitoring after WAIT: the responder owns the bus timing. din_s is ignored in RESP_*/BIT_*/END.
- Total frame time from WAIT exit: 80+80+40×50+Σhigh+50 us.
- tick coincident with a state transition is consumed by the new state's counter only if it arrives after entry. Exactly N ticks per phase; verify ±0.

Test Plan:
- Start of 18000 ticks low, then release, with bytes 0x37,0x00,0x18,0x03 → start_seen pulse; 30 us later, 80 us low and 80 us z; 40 bits decoding to 0x37 0x00 0x18 0x03 0x52; 50 us end low; frame_done one cycle; busy high throughout.
- Start low of 17999 ticks → no start_seen, bus stays z, busy=0.
- Bytes 0xFF,0xFF,0xFF,0xFF → checksum byte 0xFC; every data bit's high phase is 70 ticks except checksum bits 1 and 0, which are 26 ticks.
- Host re-pulls low 10 us into WAIT → abort: bus z, busy=0, no frame_done; a following valid 18 ms start produces a full frame.
- reset=0 asserted during bit 12 high/low phase → dht_io z immediately, busy=0; after release, IDLE accepts a new start normally.
- enable=0 with a valid start → ignored. enable dropped during RESP_LOW of an accepted frame → full 40-bit frame still sent and frame_done pulses.

Source files
------------

// File: rtl/dht11_sensor_model.sv
// DHT11 responder: waits for a host start pulse on the open-drain line, then
// plays the response preamble, a 40-bit frame (4 data bytes + checksum) and the end pulse.
module dht11_sensor_model #(
    parameter int START_MIN_US = 18000,
    parameter int WAIT_US      = 30,
    parameter int RESP_LOW_US  = 80,
    parameter int RESP_HIGH_US = 80,
    parameter int BIT_LOW_US   = 50,
    parameter int BIT0_HIGH_US = 26,
    parameter int BIT1_HIGH_US = 70,
    parameter int CNT_W        = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       enable,
    input  logic [7:0] humidity_int,
    input  logic [7:0] humidity_dec,
    input  logic [7:0] temperature_int,
    input  logic [7:0] temperature_dec,
    inout  wire        dht_io,
    output logic       busy,
    output logic       frame_done,
    output logic       start_seen
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_RESP_LOW, S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH, S_END
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt, limit;
    logic [5:0]        bit_idx, bit_idx_nxt;
    logic [39:0]       shreg, shreg_nxt;
    logic              din_meta, din_s, din_prev;
    logic              start_seen_nxt, frame_done_nxt;
    logic              phase_end;
    logic [7:0]        checksum;

    assign checksum = humidity_int + humidity_dec + temperature_int + temperature_dec;

    // Drive is decoded straight from state so an async reset frees the line at once.
    assign dht_io = (state == S_RESP_LOW || state == S_BIT_LOW || state == S_END) ? 1'b0 : 1'bz;
    assign busy   = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            din_meta   <= 1'b1;
            din_s      <= 1'b1;
            din_prev   <= 1'b1;
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            start_seen <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            din_meta   <= dht_io;
            din_s      <= din_meta;
            din_prev   <= din_s;
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            shreg      <= shreg_nxt;
            start_seen <= start_seen_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    always_comb begin
        limit = '0;
        case (state)
            S_WAIT:      limit = CNT_W'(WAIT_US - 1);
            S_RESP_LOW:  limit = CNT_W'(RESP_LOW_US - 1);
            S_RESP_HIGH: limit = CNT_W'(RESP_HIGH_US - 1);
            S_BIT_LOW:   limit = CNT_W'(BIT_LOW_US - 1);
            S_BIT_HIGH:  limit = shreg[39] ? CNT_W'(BIT1_HIGH_US - 1) : CNT_W'(BIT0_HIGH_US - 1);
            S_END:       limit = CNT_W'(BIT_LOW_US - 1);
            default:     limit = '0;
        endcase
    end

    assign phase_end = tick && (cnt == limit);

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        bit_idx_nxt    = bit_idx;
        shreg_nxt      = shreg;
        start_seen_nxt = 1'b0;
        frame_done_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (din_s && !din_prev && cnt >= CNT_W'(START_MIN_US)) begin
                    state_nxt      = S_WAIT;
                    cnt_nxt        = '0;
                    start_seen_nxt = 1'b1;
                    bit_idx_nxt    = '0;
                    shreg_nxt      = {humidity_int, humidity_dec, temperature_int,
                                      temperature_dec, checksum};
                end else if (din_s || !enable) begin
                    cnt_nxt = '0;
                end else if (tick && cnt < CNT_W'(START_MIN_US)) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_WAIT: begin
                if (!din_s) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (phase_end) begin
                    state_nxt = S_RESP_LOW;
                    cnt_nxt   = '0;
                end else if (tick) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                if (phase_end) begin
                    cnt_nxt = '0;
                    case (state)
                        S_RESP_LOW:  state_nxt = S_RESP_HIGH;
                        S_RESP_HIGH: state_nxt = S_BIT_LOW;
                        S_BIT_LOW:   state_nxt = S_BIT_HIGH;
                        // The last bit's high phase leads straight into the single trailing low.
                        S_BIT_HIGH: begin
                            shreg_nxt   = {shreg[38:0], 1'b0};
                            bit_idx_nxt = bit_idx + 1'b1;
                            state_nxt   = (bit_idx == 6'd39) ? S_END : S_BIT_LOW;
                        end
                        S_END: begin
                            state_nxt      = S_IDLE;
                            frame_done_nxt = 1'b1;
                        end
                        default:     state_nxt = S_IDLE;
                    endcase
                end else if (tick) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_dht11_sensor_model.sv
// Directed bench for dht11_sensor_model: a host model issues start pulses and
// decodes the responder's line timing in ticks against hand-computed frames.
module tb_dht11_sensor_model;

    localparam int START = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       enable = 1'b1;
    logic [7:0] hi, hd, ti, td;
    logic       host_low = 1'b0;
    logic       busy, frame_done, start_seen;
    wire        dht_io;

    int n_checks = 0;
    int n_errors = 0;
    int ss_cnt = 0;
    int fd_cnt = 0;
    int busy_low = 0;

    assign dht_io = host_low ? 1'b0 : 1'bz;
    pullup (dht_io);

    dht11_sensor_model #(.START_MIN_US(START)) dut (
        .clk(clk), .reset(rst_n), .tick(tick), .enable(enable),
        .humidity_int(hi), .humidity_dec(hd),
        .temperature_int(ti), .temperature_dec(td),
        .dht_io(dht_io), .busy(busy), .frame_done(frame_done), .start_seen(start_seen)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1 tick = ~tick;
        end
    end

    always @(posedge clk) begin
        if (start_seen) ss_cnt++;
        if (frame_done) fd_cnt++;
    end

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic host_start(input int k);
        int n = 0;
        @(posedge clk);
        #1 host_low = 1'b1;
        while (n < k) begin
            @(posedge clk);
            if (tick) n++;
        end
        #1 host_low = 1'b0;
    endtask

    task automatic wait_ticks(input int k);
        int n = 0;
        while (n < k) begin
            @(negedge clk);
            if (tick) n++;
        end
    endtask

    task automatic measure(input logic level, output int n);
        int guard = 0;
        n = 0;
        while (dht_io === level && guard < 20000) begin
            if (!busy) busy_low++;
            if (tick) n++;
            @(negedge clk);
            guard++;
        end
        if (guard >= 20000) begin
            check("phase_timeout", 40'd0, 40'd1);
            n = -1;
        end
    endtask

    task automatic wait_start(output bit found);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (start_seen) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_frame(input string tag, input logic [39:0] exp,
                             input int stop_bit, input bit drop_en);
        bit found;
        int n, bad;
        logic [39:0] data;
        wait_start(found);
        check({tag, "_start_seen"}, 40'(found), 40'd1);
        if (!found) return;
        // Inputs changed after latch must not leak into this frame.
        hi = 8'hAA; hd = 8'hAA; ti = 8'hAA; td = 8'hAA;
        busy_low = 0;
        bad = 0;
        data = '0;
        measure(1'b1, n);
        check({tag, "_wait"}, 40'(n), 40'd30);
        if (drop_en) enable = 1'b0;
        measure(1'b0, n);
        check({tag, "_resp_low"}, 40'(n), 40'd80);
        measure(1'b1, n);
        check({tag, "_resp_high"}, 40'(n), 40'd80);
        for (int i = 0; i < 40; i++) begin
            if (i == stop_bit) begin
                wait_ticks(20);
                return;
            end
            measure(1'b0, n);
            if (n != 50) bad++;
            measure(1'b1, n);
            if (n == 70)      data = {data[38:0], 1'b1};
            else if (n == 26) data = {data[38:0], 1'b0};
            else begin
                bad++;
                data = {data[38:0], 1'bx};
            end
        end
        check({tag, "_bad_phases"}, 40'(bad), 40'd0);
        check({tag, "_data"}, data, exp);
        measure(1'b0, n);
        check({tag, "_end_low"}, 40'(n), 40'd50);
        check({tag, "_busy_thru"}, 40'(busy_low), 40'd0);
        check({tag, "_frame_done"}, 40'(frame_done), 40'd1);
        check({tag, "_busy_after"}, 40'(busy), 40'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 40'(frame_done), 40'd0);
    endtask

    initial begin
        int ss0, fd0;
        bit found;
        hi = 8'h37; hd = 8'h00; ti = 8'h18; td = 8'h03;
        repeat (4) @(negedge clk);
        check("rst_busy", 40'(busy), 40'd0);
        check("rst_start_seen", 40'(start_seen), 40'd0);
        check("rst_frame_done", 40'(frame_done), 40'd0);
        check("rst_bus", 40'(dht_io), 40'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);

        host_start(START);
        run_frame("f1", 40'h37_00_18_03_52, -1, 1'b0);

        ss0 = ss_cnt;
        host_start(START - 1);
        repeat (40) @(negedge clk);
        check("short_no_start", 40'(ss_cnt), 40'(ss0));
        check("short_busy", 40'(busy), 40'd0);
        check("short_bus", 40'(dht_io), 40'd1);

        hi = 8'hFF; hd = 8'hFF; ti = 8'hFF; td = 8'hFF;
        host_start(START);
        run_frame("ff", 40'hFF_FF_FF_FF_FC, -1, 1'b0);

        fd0 = fd_cnt;
        host_start(START);
        wait_start(found);
        check("abort_start_seen", 40'(found), 40'd1);
        wait_ticks(10);
        host_low = 1'b1;
        wait_ticks(20);
        host_low = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_busy", 40'(busy), 40'd0);
        check("abort_bus", 40'(dht_io), 40'd1);
        wait_ticks(100);
        check("abort_no_done", 40'(fd_cnt), 40'(fd0));
        check("abort_bus_idle", 40'(dht_io), 40'd1);
        hi = 8'h12; hd = 8'h34; ti = 8'h56; td = 8'h78;
        host_start(START);
        run_frame("retry", 40'h12_34_56_78_14, -1, 1'b0);

        ss0 = ss_cnt;
        enable = 1'b0;
        host_start(START);
        repeat (40) @(negedge clk);
        check("dis_no_start", 40'(ss_cnt), 40'(ss0));
        check("dis_busy", 40'(busy), 40'd0);
        enable = 1'b1;
        hi = 8'h01; hd = 8'h80; ti = 8'h7F; td = 8'h00;
        host_start(START);
        run_frame("endrop", 40'h01_80_7F_00_00, -1, 1'b1);
        enable = 1'b1;

        hi = 8'h55; hd = 8'h0F; ti = 8'hF0; td = 8'h01;
        host_start(START);
        run_frame("rstmid", 40'h0, 12, 1'b0);
        check("rstmid_bus_low", 40'(dht_io), 40'd0);
        rst_n = 1'b0;
        #1;
        check("rstmid_bus_rel", 40'(dht_io), 40'd1);
        check("rstmid_busy", 40'(busy), 40'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        host_start(START);
        wait_start(found);
        check("post_rst_start", 40'(found), 40'd1);
        check("post_rst_busy", 40'(busy), 40'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
